execute_muldiv: RTL and testbench

- Multi-cycle RV M-extension unit beside the single-cycle ALU in the execute stage.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a radix-2 iterative shift-add / restoring-divide datapath.
- Parametrised in XLEN and in W-op support (32-bit ops on a 64-bit datapath).
- Uses a valid/ready handshake so the pipeline stalls while it is busy; a flush input kills in-flight work on redirects.

---
 rtl/execute_muldiv.sv | 186 ++++++++++++++++++
 tb/tb_execute_muldiv.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Multi-cycle RV M-extension unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with a valid/ready handshake and flush.
module execute_muldiv #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int W_OPS = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [7:0]       md_op_i,
   input  logic             op_w_i,
   input  logic [XLEN-1:0]  rs1_i,
   input  logic [XLEN-1:0]  rs2_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_o
);
   localparam int DW    = 2 * XLEN;
   localparam int CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state_reg, state_next;

   logic [TAG_W-1:0] tag_reg;
   logic [XLEN-1:0]  result_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             is_mul_reg, hi_reg, rem_sel_reg, iter32_reg, neg_reg;
   logic [DW-1:0]    prod_reg, mcand_reg;
   logic [XLEN-1:0]  mplier_reg;   // multiplier, or divisor for divides
   logic [XLEN-1:0]  quo_reg, rem_reg;

   logic             w_op, op_mul, op_hi, op_rem, signed_div, a_signed, b_signed;
   logic             iter32, a_neg, b_neg, a_zero, b_zero, ovf, special, accept;
   logic [CNT_W-1:0] iter;
   logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, min_neg, dividend, special_res;
   logic [DW-1:0]    prod_nx, prod_fin;
   logic [XLEN:0]    rem_shift, rem_diff;
   logic [XLEN-1:0]  rem_nx, quo_nx, quo_fin, rem_fin, div_val, mul_val, final_res;

   function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   assign in_ready_o  = (state_reg == IDLE);
   assign out_valid_o = (state_reg == DONE);
   assign result_o    = result_reg;
   assign tag_o       = tag_reg;
   assign accept      = in_valid_i & (state_reg == IDLE) & ~flush_i;

   // Decode the request: signedness, operand magnitudes and the one-edge special cases
   always_comb begin
      w_op       = op_w_i & (W_OPS != 0);
      op_mul     = |md_op_i[3:0];
      op_hi      = |md_op_i[3:1];
      op_rem     = md_op_i[6] | md_op_i[7];
      signed_div = md_op_i[4] | md_op_i[6];
      a_signed   = md_op_i[0] | md_op_i[1] | md_op_i[2] | signed_div;
      b_signed   = md_op_i[0] | md_op_i[1] | signed_div;
      iter32     = w_op | (XLEN == 32);
      iter       = iter32 ? CNT_W'(32) : CNT_W'(XLEN);
      a_ext      = w_op ? (a_signed ? sx32(rs1_i[31:0]) : XLEN'(rs1_i[31:0])) : rs1_i;
      b_ext      = w_op ? (b_signed ? sx32(rs2_i[31:0]) : XLEN'(rs2_i[31:0])) : rs2_i;
      a_neg      = a_signed & a_ext[XLEN-1];
      b_neg      = b_signed & b_ext[XLEN-1];
      a_mag      = a_neg ? -a_ext : a_ext;
      b_mag      = b_neg ? -b_ext : b_ext;
      a_zero     = (a_ext == '0);
      b_zero     = (b_ext == '0);
      min_neg    = iter32 ? sx32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
      ovf        = signed_div & (a_ext == min_neg) & (b_ext == '1);
      dividend   = iter32 ? sx32(rs1_i[31:0]) : rs1_i;
      special    = op_mul ? (a_zero | b_zero) : (b_zero | ovf);
      special_res = '0;
      if (!op_mul) begin
         if (b_zero) begin
            special_res = op_rem ? dividend : '1;
         end else if (ovf) begin
            special_res = op_rem ? '0 : a_ext;
         end
      end
   end

   // One radix-2 step of each datapath plus the sign fix-up of the final step
   always_comb begin
      prod_nx   = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
      rem_shift = {rem_reg, quo_reg[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, mplier_reg};
      if (!rem_diff[XLEN]) begin
         rem_nx = rem_diff[XLEN-1:0];
         quo_nx = {quo_reg[XLEN-2:0], 1'b1};
      end else begin
         rem_nx = rem_shift[XLEN-1:0];
         quo_nx = {quo_reg[XLEN-2:0], 1'b0};
      end
      prod_fin = neg_reg ? -prod_nx : prod_nx;
      quo_fin  = neg_reg ? -quo_nx : quo_nx;
      rem_fin  = neg_reg ? -rem_nx : rem_nx;
      div_val  = rem_sel_reg ? rem_fin : quo_fin;
      if (iter32_reg) begin
         mul_val = sx32(hi_reg ? prod_fin[63:32] : prod_fin[31:0]);
      end else begin
         mul_val = hi_reg ? prod_fin[DW-1:XLEN] : prod_fin[XLEN-1:0];
      end
      final_res = is_mul_reg ? mul_val : (iter32_reg ? sx32(div_val[31:0]) : div_val);
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; flush overrides accept and the DONE handoff
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid_i) state_next = special ? DONE : CALC;
         CALC:    if (cnt_reg <= CNT_W'(1)) state_next = DONE;
         DONE:    if (out_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_i) begin
         state_next = IDLE;
      end
   end

   // Operand capture at accept, iteration in CALC, result capture on the last step
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_reg  <= '0;
         tag_reg     <= '0;
         cnt_reg     <= '0;
         is_mul_reg  <= 1'b0;
         hi_reg      <= 1'b0;
         rem_sel_reg <= 1'b0;
         iter32_reg  <= 1'b0;
         neg_reg     <= 1'b0;
         prod_reg    <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         quo_reg     <= '0;
         rem_reg     <= '0;
      end else if (accept) begin
         tag_reg     <= tag_i;
         is_mul_reg  <= op_mul;
         hi_reg      <= op_hi;
         rem_sel_reg <= op_rem;
         iter32_reg  <= iter32;
         // remainder follows the dividend's sign, product/quotient the sign xor
         neg_reg     <= op_rem ? a_neg : (a_neg ^ b_neg);
         cnt_reg     <= iter;
         prod_reg    <= '0;
         mcand_reg   <= DW'(a_mag);
         mplier_reg  <= b_mag;
         // left-align a 32-bit dividend so the divide shifts out its MSB first
         quo_reg     <= iter32 ? (a_mag << (XLEN - 32)) : a_mag;
         rem_reg     <= '0;
         if (special) begin
            result_reg <= special_res;
         end
      end else if (state_reg == CALC && !flush_i) begin
         if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end
         if (is_mul_reg) begin
            prod_reg   <= prod_nx;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
         end else begin
            quo_reg <= quo_nx;
            rem_reg <= rem_nx;
         end
         if (cnt_reg <= CNT_W'(1)) begin
            result_reg <= final_res;
         end
      end
   end
endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized and directed bench for execute_muldiv: a 32-bit instance and a
// 64-bit instance with W ops, checked against an arithmetic reference model.
module tb_execute_muldiv;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        v32, r32, ov32, ordy32, w32, fl32;
   logic [7:0]  op32;
   logic [31:0] a32, b32, res32;
   logic [4:0]  tg32, tgo32;
   logic        v64, r64, ov64, ordy64, w64, fl64;
   logic [7:0]  op64;
   logic [63:0] a64, b64, res64;
   logic [4:0]  tg64, tgo64;

   execute_muldiv #(.XLEN(32), .TAG_W(5), .W_OPS(0)) dut32 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(v32), .in_ready_o(r32),
      .md_op_i(op32), .op_w_i(w32), .rs1_i(a32), .rs2_i(b32), .tag_i(tg32),
      .flush_i(fl32), .out_valid_o(ov32), .out_ready_i(ordy32),
      .result_o(res32), .tag_o(tgo32));

   execute_muldiv #(.XLEN(64), .TAG_W(5), .W_OPS(1)) dut64 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(v64), .in_ready_o(r64),
      .md_op_i(op64), .op_w_i(w64), .rs1_i(a64), .rs2_i(b64), .tag_i(tg64),
      .flush_i(fl64), .out_valid_o(ov64), .out_ready_i(ordy64),
      .result_o(res64), .tag_o(tgo64));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic get_ir(bit big);
      return big ? r64 : r32;
   endfunction
   function automatic logic get_ov(bit big);
      return big ? ov64 : ov32;
   endfunction
   function automatic logic [63:0] get_res(bit big);
      return big ? res64 : {32'h0, res32};
   endfunction
   function automatic logic [4:0] get_tag(bit big);
      return big ? tgo64 : tgo32;
   endfunction

   // Reference: plain wide signed arithmetic on the n-bit operands
   function automatic logic [63:0] ref_model(int op, logic [63:0] a, logic [63:0] b, int n);
      logic signed [127:0] sa, sb, ua, ub, x, y, p, q, r, minv;
      logic [127:0] t;
      logic [63:0]  res;
      if (n == 32) begin
         sa = 128'($signed(a[31:0]));
         sb = 128'($signed(b[31:0]));
         ua = 128'(a[31:0]);
         ub = 128'(b[31:0]);
      end else begin
         sa = 128'($signed(a));
         sb = 128'($signed(b));
         ua = 128'(a);
         ub = 128'(b);
      end
      minv = -(128'sd1 <<< (n - 1));
      case (op)
         0, 1:    p = sa * sb;
         2:       p = sa * ub;
         3:       p = ua * ub;
         default: p = '0;
      endcase
      if (op < 4) begin
         t = (op == 0) ? p : (p >> n);
      end else begin
         x = (op == 4 || op == 6) ? sa : ua;
         y = (op == 4 || op == 6) ? sb : ub;
         if (y == 0) begin
            q = -1;
            r = x;
         end else if ((op == 4 || op == 6) && x == minv && y == -1) begin
            q = x;
            r = 0;
         end else begin
            q = x / y;
            r = x % y;
         end
         t = (op >= 6) ? r : q;
      end
      res = t[63:0];
      if (n == 32) res = 64'($signed(res[31:0]));
      return res;
   endfunction

   function automatic int calc_lat(int op, logic [63:0] a, logic [63:0] b, int n);
      logic [63:0] mask, an, bn, minp;
      mask = (n == 32) ? 64'hFFFF_FFFF : '1;
      an   = a & mask;
      bn   = b & mask;
      minp = (n == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
      if (op < 4) return (an == 0 || bn == 0) ? 1 : n + 1;
      if (bn == 0) return 1;
      if ((op == 4 || op == 6) && an == minp && bn == mask) return 1;
      return n + 1;
   endfunction

   function automatic logic [63:0] pick(bit big);
      case ($urandom_range(0, 5))
         0:       return 64'h0;
         1:       return big ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
         2:       return big ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
         3:       return 64'($urandom_range(0, 20));
         4:       return {32'($urandom), 32'hFFFF_FFFF};
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   task automatic start_op(bit big, int op, logic [63:0] a, logic [63:0] b, bit w, logic [4:0] tag);
      @(negedge clk);
      if (big) begin
         v64 = 1'b1; op64 = 8'(1 << op); a64 = a; b64 = b; w64 = w; tg64 = tag;
      end else begin
         v32 = 1'b1; op32 = 8'(1 << op); a32 = a[31:0]; b32 = b[31:0]; tg32 = tag;
      end
      check_val("in_ready", 64'(get_ir(big)), 64'h1);
      @(posedge clk); #1;
      v32 = 1'b0;
      v64 = 1'b0;
   endtask

   // lat counts the accept edge as 1
   task automatic wait_valid(bit big, output int lat);
      lat = 1;
      while (!get_ov(big) && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("out_valid", 64'(get_ov(big)), 64'h1);
   endtask

   task automatic do_op(bit big, int op, logic [63:0] a, logic [63:0] b, bit w,
                        logic [4:0] tag, logic [63:0] exp, int exp_lat);
      int lat;
      start_op(big, op, a, b, w, tag);
      wait_valid(big, lat);
      check_val("result", get_res(big), big ? exp : {32'h0, exp[31:0]});
      check_val("tag", 64'(get_tag(big)), 64'(tag));
      check_val("latency", 64'(lat), 64'(exp_lat));
      $display("xlen=%0d op=%0d w=%0b a=%h b=%h tag=%0d res=%h lat=%0d",
               big ? 64 : 32, op, w, a, b, tag, get_res(big), lat);
      @(posedge clk); #1;
   endtask

   typedef struct {
      int          op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t dir32 [13] = '{
      '{0, 64'h7,        64'hFFFF_FFFD, 64'hFFFF_FFEB, 33},
      '{1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33},
      '{3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33},
      '{2, 64'hFFFF_FFFF, 64'h2,         64'hFFFF_FFFF, 33},
      '{4, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFD, 33},
      '{6, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFF, 33},
      '{5, 64'd100,       64'd7,         64'd14,        33},
      '{7, 64'd100,       64'd7,         64'd2,         33},
      '{4, 64'd5,         64'd0,         64'hFFFF_FFFF, 1},
      '{6, 64'd5,         64'd0,         64'd5,         1},
      '{4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1},
      '{6, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         1},
      '{0, 64'h0,         64'd123,       64'h0,         1}
   };

   initial begin
      int lat;
      int seen;
      rst = 1'b1;
      v32 = 0; op32 = 0; w32 = 0; a32 = 0; b32 = 0; tg32 = 0; fl32 = 0; ordy32 = 1;
      v64 = 0; op64 = 0; w64 = 0; a64 = 0; b64 = 0; tg64 = 0; fl64 = 0; ordy64 = 1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_in_ready32", 64'(r32), 64'h1);
      check_val("rst_out_valid32", 64'(ov32), 64'h0);
      check_val("rst_result32", 64'(res32), 64'h0);
      check_val("rst_tag32", 64'(tgo32), 64'h0);
      check_val("rst_in_ready64", 64'(r64), 64'h1);
      check_val("rst_result64", res64, 64'h0);
      rst = 1'b0;

      foreach (dir32[i])
         do_op(0, dir32[i].op, dir32[i].a, dir32[i].b, 0, 5'(i), dir32[i].exp, dir32[i].lat);

      // Backpressure: result held while the consumer stalls
      ordy32 = 1'b0;
      start_op(0, 5, 64'd100, 64'd7, 0, 5'd9);
      wait_valid(0, lat);
      check_val("bp_latency", 64'(lat), 64'd33);
      @(negedge clk);
      v32 = 1'b1; op32 = 8'h01; a32 = 32'd3; b32 = 32'd3; tg32 = 5'd20;
      repeat (5) begin
         @(posedge clk); #1;
         check_val("bp_result", 64'(res32), 64'd14);
         check_val("bp_tag", 64'(tgo32), 64'd9);
         check_val("bp_in_ready", 64'(r32), 64'h0);
         check_val("bp_out_valid", 64'(ov32), 64'h1);
      end
      @(negedge clk);
      v32 = 1'b0;
      ordy32 = 1'b1;
      @(posedge clk); #1;
      check_val("bp_release_in_ready", 64'(r32), 64'h1);
      check_val("bp_release_out_valid", 64'(ov32), 64'h0);
      do_op(0, 5, 64'd50, 64'd5, 0, 5'd1, 64'd10, 33);
      do_op(0, 0, 64'd6, 64'd7, 0, 5'd2, 64'd42, 33);
      do_op(0, 7, 64'd50, 64'd7, 0, 5'd3, 64'd1, 33);

      // Flush in the middle of CALC
      start_op(0, 0, 64'd3, 64'd5, 0, 5'd4);
      repeat (10) @(posedge clk);
      @(negedge clk);
      fl32 = 1'b1;
      @(posedge clk); #1;
      fl32 = 1'b0;
      check_val("flush_out_valid", 64'(ov32), 64'h0);
      check_val("flush_in_ready", 64'(r32), 64'h1);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ov32) seen++;
      end
      check_val("flush_no_valid", 64'(seen), 64'h0);
      do_op(0, 5, 64'd9, 64'd3, 0, 5'd6, 64'd3, 33);

      // Reset in the middle of CALC
      start_op(0, 0, 64'd3, 64'd5, 0, 5'd7);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("midrst_in_ready", 64'(r32), 64'h1);
      check_val("midrst_out_valid", 64'(ov32), 64'h0);
      check_val("midrst_result", 64'(res32), 64'h0);
      check_val("midrst_tag", 64'(tgo32), 64'h0);

      for (int i = 0; i < 40; i++) begin
         int          op;
         logic [63:0] a, b;
         op = $urandom_range(0, 7);
         a  = pick(0);
         b  = pick(0);
         do_op(0, op, a, b, 0, 5'($urandom), ref_model(op, a, b, 32), calc_lat(op, a, b, 32));
      end

      do_op(1, 0, 64'h7FFF_FFFF, 64'd2, 1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33);
      do_op(1, 4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5'd4,
            64'h8000_0000_0000_0000, 1);

      for (int i = 0; i < 30; i++) begin
         int          op, n;
         bit          w;
         logic [63:0] a, b;
         op = $urandom_range(0, 7);
         w  = 1'($urandom_range(0, 1));
         n  = w ? 32 : 64;
         a  = pick(1);
         b  = pick(1);
         do_op(1, op, a, b, w, 5'($urandom), ref_model(op, a, b, n), calc_lat(op, a, b, n));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
